// File: rtl/hack_ctrl.sv
// Hack CPU controller: three-cycle FETCH/EXEC/COMMIT sequencer owning A, D and pc, with an external ALU.
// Optional retired-instruction counter enabled by defining HACK_CTRL_RETIRE_CNT_EN.
module hack_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [0:15] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [0:15] pc,
  output logic [0:15] alu_x,
  output logic [0:15] alu_y,
  output logic        alu_zx,
  output logic        alu_nx,
  output logic        alu_zy,
  output logic        alu_ny,
  output logic        alu_f,
  output logic        alu_no,
  input  logic [0:15] alu_out,
  input  logic        alu_zr,
  input  logic        alu_ng,
  input  logic [0:15] mem_in,
  output logic [0:15] mem_addr,
  output logic [0:15] mem_out,
  output logic        mem_we
`ifdef HACK_CTRL_RETIRE_CNT_EN
  ,
  output logic [0:15] retired
`endif
);

  // Hack bit b lives at vector index 15-b.
  localparam int I_CI = 0;   // bit 15: C-instruction
  localparam int I_AM = 3;   // bit 12: operand y from M
  localparam int I_D1 = 10;  // bit 5: dest A
  localparam int I_D2 = 11;  // bit 4: dest D
  localparam int I_D3 = 12;  // bit 3: dest M
  localparam int I_J1 = 13;
  localparam int I_J2 = 14;
  localparam int I_J3 = 15;

  typedef enum logic [1:0] {FETCH, EXEC, COMMIT} state_t;

  state_t      state, state_nxt;
  logic [0:15] ir, a_reg, d_reg, res;
  logic        res_zr, res_ng;
  logic        is_c, jump;
  logic        unused_bits;

  assign is_c        = ir[I_CI];
  assign unused_bits = ^ir[1:2];
  assign alu_x       = d_reg;
  assign alu_y       = ir[I_AM] ? mem_in : a_reg;
  assign mem_addr    = a_reg;
  assign mem_out     = res;
  assign jump        = is_c & ((ir[I_J1] & res_ng) | (ir[I_J2] & res_zr) |
                               (ir[I_J3] & ~res_ng & ~res_zr));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    mem_we      = 1'b0;
    {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = 6'b0;
    case (state)
      FETCH: begin
        instr_ready = 1'b1;
        if (instr_valid) state_nxt = EXEC;
      end
      EXEC: begin
        // A-instructions leave the ALU idle.
        if (is_c) {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = ir[4:9];
        state_nxt = COMMIT;
      end
      COMMIT: begin
        mem_we    = is_c & ir[I_D3];
        state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir     <= '0;
      a_reg  <= '0;
      d_reg  <= '0;
      pc     <= '0;
      res    <= '0;
      res_zr <= 1'b0;
      res_ng <= 1'b0;
    end else begin
      if (state == FETCH && instr_valid) ir <= instr;
      if (state == EXEC) begin
        res    <= alu_out;
        res_zr <= alu_zr;
        res_ng <= alu_ng;
      end
      if (state == COMMIT) begin
        // Jump target reads the pre-update A, so A-writes and jumps in one instruction compose.
        if (is_c) begin
          if (ir[I_D1]) a_reg <= res;
          if (ir[I_D2]) d_reg <= res;
        end else begin
          a_reg <= ir;
        end
        pc <= jump ? a_reg : pc + 16'd1;
      end
    end
  end

`ifdef HACK_CTRL_RETIRE_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                retired <= '0;
    else if (state == COMMIT)  retired <= retired + 16'd1;
  end
`endif

endmodule

// File: tb/tb_hack_ctrl.sv
// Self-checking bench for hack_ctrl: directed Hack programs plus randomized instruction streams
// compared every cycle against an instruction-level reference model.
module tb_hack_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [0:15] instr = '0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [0:15] pc, alu_x, alu_y, alu_out, mem_in, mem_addr, mem_out;
  logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no, alu_zr, alu_ng, mem_we;
`ifdef HACK_CTRL_RETIRE_CNT_EN
  logic [0:15] retired;
`endif

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hack_ctrl dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .pc(pc), .alu_x(alu_x), .alu_y(alu_y),
    .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy), .alu_ny(alu_ny),
    .alu_f(alu_f), .alu_no(alu_no), .alu_out(alu_out), .alu_zr(alu_zr),
    .alu_ng(alu_ng), .mem_in(mem_in), .mem_addr(mem_addr), .mem_out(mem_out),
    .mem_we(mem_we)
`ifdef HACK_CTRL_RETIRE_CNT_EN
    , .retired(retired)
`endif
  );

  // Hack ALU: c = {zx,nx,zy,ny,f,no}
  function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                           input logic [5:0] c);
    logic [15:0] xx, yy, o;
    xx = c[5] ? 16'h0 : x;
    xx = c[4] ? ~xx : xx;
    yy = c[3] ? 16'h0 : y;
    yy = c[2] ? ~yy : yy;
    o  = c[1] ? xx + yy : xx & yy;
    return c[0] ? ~o : o;
  endfunction

  function automatic logic [15:0] memf(input logic [15:0] addr);
    return addr ^ 16'h5A3C;
  endfunction

  logic [5:0] ctl_bus;
  assign ctl_bus = {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no};
  assign alu_out = hack_alu(alu_x, alu_y, ctl_bus);
  assign alu_zr  = (alu_out == 16'h0);
  assign alu_ng  = alu_out[0];
  assign mem_in  = memf(mem_addr);

  task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  // Instruction-level model: the whole effect of an instruction is computed when it is accepted,
  // then becomes architecturally visible two cycles later.
  int          m_phase = 0;
  logic [15:0] m_a = 0, m_d = 0, m_pc = 0, m_h = 0, m_res = 0, m_ret = 0;
  logic [15:0] m_na = 0, m_nd = 0, m_npc = 0;
  logic        m_we = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_a = 0; m_d = 0; m_pc = 0; m_res = 0; m_ret = 0; m_we = 0; m_h = 0;
    end else begin
      case (m_phase)
        0: if (instr_valid) begin
          logic [15:0] y, r;
          logic        jmp;
          m_h = instr;
          if (!m_h[15]) begin
            m_na = m_h; m_nd = m_d; m_npc = m_pc + 16'd1; m_we = 0;
          end else begin
            y     = m_h[12] ? memf(m_a) : m_a;
            r     = hack_alu(m_d, y, m_h[11:6]);
            m_res = r;
            m_we  = m_h[3];
            m_na  = m_h[5] ? r : m_a;
            m_nd  = m_h[4] ? r : m_d;
            jmp   = (m_h[2] && $signed(r) < 0) || (m_h[1] && r == 0) ||
                    (m_h[0] && $signed(r) > 0);
            m_npc = jmp ? m_a : m_pc + 16'd1;
          end
          m_phase = 1;
        end
        1: m_phase = 2;
        default: begin
          m_a = m_na; m_d = m_nd; m_pc = m_npc; m_ret = m_ret + 16'd1;
          m_phase = 0;
        end
      endcase
    end
  end

  int          we_cnt = 0;
  logic [15:0] we_addr = 0, we_data = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("instr_ready", {15'b0, instr_ready}, {15'b0, m_phase == 0});
      chk("pc", pc, m_pc);
      chk("A", mem_addr, m_a);
      chk("D", alu_x, m_d);
      chk("mem_we", {15'b0, mem_we}, {15'b0, m_phase == 2 && m_h[15] && m_we});
      if (mem_we) begin
        chk("mem_out", mem_out, m_res);
        we_cnt++; we_addr = mem_addr; we_data = mem_out;
      end
      if (m_phase == 1 && m_h[15]) begin
        chk("alu_ctl", {10'b0, ctl_bus}, {10'b0, m_h[11:6]});
        chk("alu_y", alu_y, m_h[12] ? memf(m_a) : m_a);
      end else begin
        chk("alu_ctl_idle", {10'b0, ctl_bus}, 16'h0);
      end
`ifdef HACK_CTRL_RETIRE_CNT_EN
      chk("retired", retired, m_ret);
`endif
    end
  end

  task automatic issue(input logic [15:0] w, output logic [5:0] ctl);
    bit got;
    got = 0;
    instr = w; instr_valid = 1'b1;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk); got = instr_ready;
      @(posedge clk);
    end
    #2 instr_valid = 1'b0; instr = 16'hFFFF;
    if (!got) chk("accept_timeout", 16'h0, 16'h1);
    @(negedge clk); ctl = ctl_bus;
    @(posedge clk); @(posedge clk); #2;
  endtask

  initial begin
    logic [5:0]  ctl;
    logic [15:0] pc0;
    int          we0;

    repeat (3) @(posedge clk);
    #2;
    chk("rst_pc", pc, 16'h0);
    chk("rst_A", mem_addr, 16'h0);
    chk("rst_D", alu_x, 16'h0);
    chk("rst_we", {15'b0, mem_we}, 16'h0);
    chk("rst_ctl", {10'b0, ctl_bus}, 16'h0);
    rst_n = 1'b1;
    @(posedge clk); #2;
    chk("ready_after_rst", {15'b0, instr_ready}, 16'h1);

    we0 = we_cnt;
    issue(16'h0005, ctl);
    chk("ainst_A", mem_addr, 16'h0005);
    chk("ainst_pc", pc, 16'h0001);
    chk("ainst_ctl", {10'b0, ctl}, 16'h0);
    issue(16'hEC10, ctl);
    chk("d_eq_a_ctl", {10'b0, ctl}, 16'b110000);
    chk("d_eq_a_D", alu_x, 16'h0005);
    chk("d_eq_a_pc", pc, 16'h0002);
    chk("no_we_yet", we_cnt[15:0], we0[15:0]);
    issue(16'hE7C8, ctl);
    chk("m_write_cnt", we_cnt[15:0], we0[15:0] + 16'd1);
    chk("m_write_addr", we_addr, 16'h0005);
    chk("m_write_data", we_data, 16'h0006);
    chk("m_write_A", mem_addr, 16'h0005);
    chk("m_write_D", alu_x, 16'h0005);

    issue(16'h0014, ctl);
    issue(16'hE301, ctl);
    chk("jgt_taken", pc, 16'h0014);
    issue(16'hEA90, ctl);
    chk("d_zero", alu_x, 16'h0000);
    issue(16'hE301, ctl);
    chk("jgt_not_taken", pc, 16'h0016);
    issue(16'hEA87, ctl);
    chk("jmp", pc, 16'h0014);
    chk("model_pc_pin", m_pc, 16'h0014);

    pc0 = pc;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_ready", {15'b0, instr_ready}, 16'h1);
      chk("stall_pc", pc, pc0);
    end
    @(posedge clk); #2;

    issue(16'hEEA0, ctl);
    chk("a_minus1", mem_addr, 16'hFFFF);
    issue(16'hEA87, ctl);
    chk("pc_ffff", pc, 16'hFFFF);
    issue(16'hEA90, ctl);
    chk("pc_wrap", pc, 16'h0000);
    chk("model_wrap_pin", m_pc, 16'h0000);

    issue(16'h0005, ctl);
    issue(16'hEC10, ctl);
    instr = 16'hE7C8; instr_valid = 1'b1;
    begin
      bit got;
      got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
        @(negedge clk); got = instr_ready;
        @(posedge clk);
      end
      if (!got) chk("accept_timeout", 16'h0, 16'h1);
    end
    #2 instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("commit_we", {15'b0, mem_we}, 16'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_we", {15'b0, mem_we}, 16'h0);
    chk("midrst_A", mem_addr, 16'h0);
    chk("midrst_D", alu_x, 16'h0);
    chk("midrst_pc", pc, 16'h0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #2;
    chk("post_rst_A", mem_addr, 16'h0);
    chk("post_rst_pc", pc, 16'h0);

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      instr_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) instr = {1'b0, 15'($urandom())};
      else                          instr = {1'b1, 15'($urandom())};
    end
    instr_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
